// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory and fetch-output handshake bundle
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   // fetch unit side
   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output instr_valid, instr, instr_pc,
      input  instr_ready
   );

   // memory plus decode side
   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  instr_valid, instr, instr_pc,
      output instr_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch with PC/word FIFO and redirect flush (optional FETCH_STATS_EN counters)
module instr_fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   instr_fetch_unit_if.master bus,
   output logic               busy
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]        stat_fetched,
   output logic [31:0]        stat_dropped
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   state_t        state;
   logic [31:0]   fetch_pc;
   logic [31:0]   fetch_pc_nxt;
   logic [31:0]   mem_instr [DEPTH];
   logic [31:0]   mem_pc    [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_ptr_nxt;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          push;
   logic          pop;
   logic          space_nxt;
   logic          redirect_pc_unused;

   // low address bits of the redirect target are forced to zero
   assign redirect_pc_unused = ^redirect_pc[1:0];

   assign busy = (state != IDLE);

   // push/pop decisions; redirect overrides both and empties the FIFO
   always_comb begin
      push = (state == REQ) && bus.imem_ack && !redirect;
      pop  = bus.instr_valid && bus.instr_ready && !redirect;

      count_nxt = count;
      if (redirect)
         count_nxt = '0;
      else if (push && !pop)
         count_nxt = count + 1'b1;
      else if (pop && !push)
         count_nxt = count - 1'b1;

      // a new request is only issued when its word is sure to fit
      space_nxt = (count_nxt < DEPTH_C);

      rd_ptr_nxt = rd_ptr;
      if (redirect)
         rd_ptr_nxt = '0;
      else if (pop)
         rd_ptr_nxt = rd_ptr + 1'b1;

      fetch_pc_nxt = fetch_pc;
      if (redirect)
         fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
      else if (push)
         fetch_pc_nxt = fetch_pc + 32'd4;
   end

   // request FSM; imem_addr doubles as the drop address while in DROP
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         fetch_pc      <= RESET_PC;
         bus.imem_req  <= 1'b0;
         bus.imem_addr <= RESET_PC;
      end else begin
         fetch_pc <= fetch_pc_nxt;
         case (state)
            IDLE: begin
               if (space_nxt) begin
                  state         <= REQ;
                  bus.imem_req  <= 1'b1;
                  bus.imem_addr <= fetch_pc_nxt;
               end
            end
            REQ: begin
               if (bus.imem_ack) begin
                  if (!redirect && space_nxt) begin
                     bus.imem_addr <= fetch_pc_nxt;
                  end else begin
                     state        <= IDLE;
                     bus.imem_req <= 1'b0;
                  end
               end else if (redirect) begin
                  state <= DROP;
               end
            end
            DROP: begin
               if (bus.imem_ack) begin
                  state        <= IDLE;
                  bus.imem_req <= 1'b0;
               end
            end
            default: begin
               state        <= IDLE;
               bus.imem_req <= 1'b0;
            end
         endcase
      end
   end

   // FIFO storage; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= bus.imem_rdata;
         mem_pc[wr_ptr]    <= fetch_pc;
      end
   end

   // FIFO pointers and registered head, bypassing a push into an empty slot
   always_ff @(posedge clk) begin
      if (!rst) begin
         count           <= '0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         bus.instr_valid <= 1'b0;
         bus.instr       <= '0;
         bus.instr_pc    <= '0;
      end else begin
         count           <= count_nxt;
         rd_ptr          <= rd_ptr_nxt;
         bus.instr_valid <= (count_nxt != '0);
         if (redirect)
            wr_ptr <= '0;
         else if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (count_nxt != '0) begin
            if (push && (rd_ptr_nxt == wr_ptr)) begin
               bus.instr    <= bus.imem_rdata;
               bus.instr_pc <= fetch_pc;
            end else begin
               bus.instr    <= mem_instr[rd_ptr_nxt];
               bus.instr_pc <= mem_pc[rd_ptr_nxt];
            end
         end
      end
   end

`ifdef FETCH_STATS_EN
   logic discard;

   assign discard = bus.imem_ack && (((state == REQ) && redirect) || (state == DROP));

   // fetched words and discarded work (dropped responses plus flushed entries)
   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_fetched <= '0;
         stat_dropped <= '0;
      end else begin
         if (push)
            stat_fetched <= stat_fetched + 32'd1;
         stat_dropped <= stat_dropped + 32'(discard) + (redirect ? 32'(count) : 32'd0);
      end
   end
`endif

endmodule
